// File: rtl/otter_lsu_split_if.sv
// Bus bundle between the pipeline MEM stage, the load/store unit and
// data port 2 of the OTTER memory.
interface otter_lsu_split_if;
    // pipeline request
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [1:0]  req_size;
    logic        req_sign;
    // pipeline response
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    // memory data port 2
    logic [31:0] mem_addr2;
    logic [31:0] mem_din2;
    logic        mem_write2;
    logic        mem_read2;
    logic [1:0]  mem_size;
    logic        mem_sign;
    logic [31:0] mem_dout2;

    // LSU side: takes requests, initiates memory operations
    modport master (
        input  req_valid, req_we, req_addr, req_wdata, req_size, req_sign, mem_dout2,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
        output mem_addr2, mem_din2, mem_write2, mem_read2, mem_size, mem_sign
    );

    // pipeline + memory side
    modport slave (
        output req_valid, req_we, req_addr, req_wdata, req_size, req_sign, mem_dout2,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
        input  mem_addr2, mem_din2, mem_write2, mem_read2, mem_size, mem_sign
    );
endinterface

// File: rtl/otter_lsu_split.sv
// Load/store initiator for OTTER data port 2. Aligned / non-word-crossing
// accesses go out as one memory op; word-crossing accesses are split into
// sequential byte ops and reassembled little-endian. MMIO is never split.
module otter_lsu_split #(
    parameter int unsigned MEM_BYTES = 65536,
    parameter logic [31:0] IO_BASE   = 32'h1100_0000
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    otter_lsu_split_if.master bus
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

    localparam logic [32:0] MEM_LIMIT = 33'(MEM_BYTES);
    localparam logic [32:0] IO_LIMIT  = {1'b0, IO_BASE};

    state_t      state_q, state_d;
    logic [1:0]  k_q, k_d;            // index of the op currently on the bus
    logic [1:0]  nlast_q, nlast_d;    // index of the final op (N-1)
    logic        split_q, split_d;
    logic        we_q, we_d;
    logic        sign_q, sign_d;
    logic [1:0]  size_q, size_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] acc_q, acc_d;        // byte accumulator for split loads

    logic [31:0] mem_addr2_q, mem_addr2_d;
    logic [31:0] mem_din2_q, mem_din2_d;
    logic        mem_write2_q, mem_write2_d;
    logic        mem_read2_q, mem_read2_d;
    logic [1:0]  mem_size_q, mem_size_d;
    logic        mem_sign_q, mem_sign_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
    logic        rsp_err_q, rsp_err_d;

    // request decode (only meaningful in IDLE)
    logic [1:0]  req_span;
    logic [32:0] req_last_byte;
    logic        req_io, req_err, req_cross;
    logic [1:0]  req_nlast;

    // split-load byte capture and final assembly
    logic [1:0]  cap_idx;
    logic [31:0] acc_cap;
    logic [31:0] split_result;
    logic [1:0]  k_inc;

    // Classify the incoming request: range/size error, MMIO, word crossing
    always_comb begin
        case (bus.req_size)
            2'd0:    req_span = 2'd0;
            2'd1:    req_span = 2'd1;
            default: req_span = 2'd3;
        endcase
        req_io        = (bus.req_addr >= IO_BASE);
        req_last_byte = {1'b0, bus.req_addr} + {31'b0, req_span};
        req_err       = (bus.req_size == 2'd3) ||
                        (!req_io && ((req_last_byte >= MEM_LIMIT) || (req_last_byte >= IO_LIMIT)));
        req_cross     = !req_io &&
                        (((bus.req_size == 2'd1) && (bus.req_addr[1:0] == 2'd3)) ||
                         ((bus.req_size == 2'd2) && (bus.req_addr[1:0] != 2'd0)));
        if (!req_cross)
            req_nlast = 2'd0;
        else if (bus.req_size == 2'd1)
            req_nlast = 2'd1;
        else
            req_nlast = 2'd3;
    end

    // Merge the byte returned for the previous read op into the accumulator
    always_comb begin
        cap_idx = (state_q == S_ISSUE) ? (k_q - 2'd1) : k_q;
        acc_cap = acc_q;
        acc_cap[{cap_idx, 3'b000} +: 8] = bus.mem_dout2[7:0];
        if (size_q == 2'd1)
            split_result = sign_q ? {16'b0, acc_cap[15:0]} : {{16{acc_cap[15]}}, acc_cap[15:0]};
        else
            split_result = acc_cap;
    end

    // Next-state and registered-output logic of the issue FSM
    always_comb begin
        state_d      = state_q;
        k_d          = k_q;
        nlast_d      = nlast_q;
        split_d      = split_q;
        we_d         = we_q;
        sign_d       = sign_q;
        size_d       = size_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        acc_d        = acc_q;
        mem_addr2_d  = mem_addr2_q;
        mem_din2_d   = mem_din2_q;
        mem_size_d   = mem_size_q;
        mem_sign_d   = mem_sign_q;
        mem_write2_d = 1'b0;
        mem_read2_d  = 1'b0;
        rsp_valid_d  = 1'b0;
        rsp_err_d    = 1'b0;
        rsp_rdata_d  = rsp_rdata_q;
        k_inc        = k_q + 2'd1;

        case (state_q)
            S_IDLE: begin
                if (bus.req_valid) begin
                    if (req_err) begin
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                    end else begin
                        state_d      = S_ISSUE;
                        k_d          = 2'd0;
                        nlast_d      = req_nlast;
                        split_d      = req_cross;
                        we_d         = bus.req_we;
                        sign_d       = bus.req_sign;
                        size_d       = bus.req_size;
                        addr_d       = bus.req_addr;
                        wdata_d      = bus.req_wdata;
                        acc_d        = 32'b0;
                        mem_addr2_d  = bus.req_addr;
                        mem_write2_d = bus.req_we;
                        mem_read2_d  = !bus.req_we;
                        if (req_cross) begin
                            mem_size_d = 2'd0;
                            mem_sign_d = 1'b1;
                            mem_din2_d = {24'b0, bus.req_wdata[7:0]};
                        end else begin
                            mem_size_d = req_io ? 2'd2 : bus.req_size;
                            mem_sign_d = bus.req_sign;
                            mem_din2_d = bus.req_wdata;
                        end
                    end
                end
            end
            S_ISSUE: begin
                if (!we_q && (k_q != 2'd0))
                    acc_d = acc_cap;
                if (k_q != nlast_q) begin
                    k_d          = k_inc;
                    mem_addr2_d  = addr_q + {30'b0, k_inc};
                    mem_din2_d   = {24'b0, wdata_q[{k_inc, 3'b000} +: 8]};
                    mem_write2_d = we_q;
                    mem_read2_d  = !we_q;
                end else if (we_q) begin
                    state_d     = S_IDLE;
                    rsp_valid_d = 1'b1;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                state_d     = S_IDLE;
                rsp_valid_d = 1'b1;
                acc_d       = acc_cap;
                rsp_rdata_d = split_q ? split_result : bus.mem_dout2;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and output registers; reset aborts any op in flight
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q      <= S_IDLE;
            k_q          <= 2'd0;
            nlast_q      <= 2'd0;
            split_q      <= 1'b0;
            we_q         <= 1'b0;
            sign_q       <= 1'b0;
            size_q       <= 2'd0;
            addr_q       <= 32'b0;
            wdata_q      <= 32'b0;
            acc_q        <= 32'b0;
            mem_addr2_q  <= 32'b0;
            mem_din2_q   <= 32'b0;
            mem_write2_q <= 1'b0;
            mem_read2_q  <= 1'b0;
            mem_size_q   <= 2'd0;
            mem_sign_q   <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_rdata_q  <= 32'b0;
            rsp_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            k_q          <= k_d;
            nlast_q      <= nlast_d;
            split_q      <= split_d;
            we_q         <= we_d;
            sign_q       <= sign_d;
            size_q       <= size_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            acc_q        <= acc_d;
            mem_addr2_q  <= mem_addr2_d;
            mem_din2_q   <= mem_din2_d;
            mem_write2_q <= mem_write2_d;
            mem_read2_q  <= mem_read2_d;
            mem_size_q   <= mem_size_d;
            mem_sign_q   <= mem_sign_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_rdata_q  <= rsp_rdata_d;
            rsp_err_q    <= rsp_err_d;
        end
    end

    assign bus.req_ready  = (state_q == S_IDLE);
    assign bus.mem_addr2  = mem_addr2_q;
    assign bus.mem_din2   = mem_din2_q;
    assign bus.mem_write2 = mem_write2_q;
    assign bus.mem_read2  = mem_read2_q;
    assign bus.mem_size   = mem_size_q;
    assign bus.mem_sign   = mem_sign_q;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_rdata  = rsp_rdata_q;
    assign bus.rsp_err    = rsp_err_q;

endmodule
